// File: rtl/sb_axil_pkg.sv
// sb_axil_pkg: register map, response codes, FSM state types and helpers shared by sb_axil_regs.
// SB_BLINK_CNT_READ_EN adds the read-only CNT register at offset 0x10.
package sb_axil_pkg;
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DIV = 3'd1;
  localparam logic [2:0] REG_SCRATCH = 3'd2;
  localparam logic [2:0] REG_ID = 3'd3;
  localparam logic [2:0] REG_CNT = 3'd4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CTRL_LED_FORCE = 0;
  localparam int CTRL_BLINK_EN = 1;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  function automatic logic [31:0] merge_wstrb(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
  // Word index (addr[4:2]) that answers OKAY; everything above is SLVERR.
  function automatic logic reg_mapped(input logic [2:0] idx);
`ifdef SB_BLINK_CNT_READ_EN
    return idx <= REG_CNT;
`else
    return idx <= REG_ID;
`endif
  endfunction
endpackage

// File: rtl/sb_led_blinker.sv
// sb_led_blinker: free-running divider that toggles blink each time cnt reaches div.
module sb_led_blinker (
  input  logic        clk_axi,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] div,
  output logic [31:0] cnt,
  output logic        blink
);
  // >= rather than == so that lowering div below cnt wraps immediately.
  always_ff @(posedge clk_axi) begin
    if (rst || !en) begin
      cnt <= '0;
      blink <= 1'b0;
    end else if (cnt >= div) begin
      cnt <= '0;
      blink <= ~blink;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: rtl/sb_axil_regs.sv
// sb_axil_regs: AXI4-Lite slave with CTRL/BLINK_DIV/SCRATCH/ID registers driving the board LED.
// SB_BLINK_CNT_READ_EN exposes the live blink counter at offset 0x10.
module sb_axil_regs
  import sb_axil_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] ID_VALUE = 32'h5B1C_0001,
  parameter logic [31:0] DIV_RST  = 32'd49_999_999
) (
  input  logic              clk_axi,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              led
);
  if (DATA_W != 32) begin : g_bad_data_w
    $error("sb_axil_regs: DATA_W must be 32");
  end
  if (ADDR_W < 5) begin : g_bad_addr_w
    $error("sb_axil_regs: ADDR_W must be at least 5");
  end
  wr_state_t   wr_state;
  rd_state_t   rd_state;
  logic        aw_held, w_held, aw_hs, w_hs, ar_hs, aw_now, w_now;
  logic [2:0]  aw_idx, wr_idx, rd_idx;
  logic [31:0] w_data, wr_d, rd_val, div, scratch, blink_cnt;
  logic [3:0]  w_strb, wr_s;
  logic [1:0]  ctrl;
  logic        blink;
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr, s_araddr};
  // Same-cycle AW/W handshakes are merged with anything already latched.
  always_comb begin
    aw_hs = s_awvalid && s_awready;
    w_hs = s_wvalid && s_wready;
    ar_hs = s_arvalid && s_arready;
    aw_now = aw_held || aw_hs;
    w_now = w_held || w_hs;
    wr_idx = aw_held ? aw_idx : s_awaddr[4:2];
    wr_d = w_held ? w_data : s_wdata;
    wr_s = w_held ? w_strb : s_wstrb;
    rd_idx = s_araddr[4:2];
    rd_val = rd_idx == REG_CTRL ? {30'd0, ctrl} :
             rd_idx == REG_DIV ? div :
             rd_idx == REG_SCRATCH ? scratch :
             rd_idx == REG_ID ? ID_VALUE :
`ifdef SB_BLINK_CNT_READ_EN
             rd_idx == REG_CNT ? blink_cnt :
`endif
             32'd0;
  end
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      s_awready <= 1'b0;
      s_wready <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp <= RESP_OKAY;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      ctrl <= '0;
      div <= DIV_RST;
      scratch <= '0;
    end else if (wr_state == WR_IDLE) begin
      if (aw_hs) aw_idx <= s_awaddr[4:2];
      if (w_hs) begin
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (aw_now && w_now) begin
        wr_state <= WR_RESP;
        aw_held <= 1'b1;
        w_held <= 1'b1;
        s_awready <= 1'b0;
        s_wready <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp <= reg_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
        if (wr_idx == REG_CTRL && wr_s[0]) ctrl <= wr_d[1:0];
        if (wr_idx == REG_DIV) div <= merge_wstrb(div, wr_d, wr_s);
        if (wr_idx == REG_SCRATCH) scratch <= merge_wstrb(scratch, wr_d, wr_s);
      end else begin
        aw_held <= aw_now;
        w_held <= w_now;
        s_awready <= !aw_now;
        s_wready <= !w_now;
      end
    end else if (s_bready) begin
      wr_state <= WR_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      s_awready <= 1'b1;
      s_wready <= 1'b1;
      s_bvalid <= 1'b0;
    end
  end
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      s_arready <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else if (rd_state == RD_IDLE) begin
      s_arready <= !ar_hs;
      if (ar_hs) begin
        rd_state <= RD_DATA;
        s_rvalid <= 1'b1;
        s_rdata <= rd_val;
        s_rresp <= reg_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (s_rready) begin
      rd_state <= RD_IDLE;
      s_arready <= 1'b1;
      s_rvalid <= 1'b0;
    end
  end
  sb_led_blinker u_blink (
    .clk_axi(clk_axi),
    .rst(rst),
    .en(ctrl[CTRL_BLINK_EN]),
    .div(div),
    .cnt(blink_cnt),
    .blink(blink)
  );
  always_ff @(posedge clk_axi) begin
    if (rst) led <= 1'b0;
    else led <= ctrl[CTRL_BLINK_EN] ? blink : ctrl[CTRL_LED_FORCE];
  end
endmodule

// File: tb/tb_sb_axil_regs.sv
// tb_sb_axil_regs: directed self-checking bench for sb_axil_regs.
// Honours SB_BLINK_CNT_READ_EN to check either the CNT register or its SLVERR decode.
module tb_sb_axil_regs;
  logic        clk_axi, rst;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, led;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  int vecs = 0;
  int errs = 0;

  sb_axil_regs dut (
    .clk_axi(clk_axi), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .led(led)
  );

  initial clk_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_axi);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st, output logic [1:0] resp);
    int n;
    bit got, aw_hs, w_hs, b_hs;
    s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = st; s_wvalid = 1; s_bready = 1;
    got = 0; n = 0; resp = 2'bxx;
    while (!got && n < 50) begin
      aw_hs = s_awvalid && s_awready;
      w_hs = s_wvalid && s_wready;
      b_hs = s_bvalid && s_bready;
      if (b_hs) resp = s_bresp;
      tick; n++;
      if (aw_hs) s_awvalid = 0;
      if (w_hs) s_wvalid = 0;
      if (b_hs) got = 1;
    end
    s_awvalid = 0; s_wvalid = 0; s_bready = 0;
    if (!got) begin
      vecs++; errs++;
      $display("FAIL write_timeout addr=%h", a);
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit got, ar_hs, r_hs;
    s_araddr = a; s_arvalid = 1; s_rready = 1;
    got = 0; n = 0; d = 'x; resp = 2'bxx;
    while (!got && n < 50) begin
      ar_hs = s_arvalid && s_arready;
      r_hs = s_rvalid && s_rready;
      if (r_hs) begin
        d = s_rdata;
        resp = s_rresp;
      end
      tick; n++;
      if (ar_hs) s_arvalid = 0;
      if (r_hs) got = 1;
    end
    s_arvalid = 0; s_rready = 0;
    if (!got) begin
      vecs++; errs++;
      $display("FAIL read_timeout addr=%h", a);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [1:0] r;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0; rst = 1;
    tick; tick;
    vecs++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errs++; $display("FAIL rst_readies got=%b exp=000", {s_awready, s_wready, s_arready}); end
    vecs++; if ({s_bvalid, s_rvalid, led, s_bresp, s_rresp} !== 7'd0) begin errs++; $display("FAIL rst_outputs got=%b exp=0", {s_bvalid, s_rvalid, led, s_bresp, s_rresp}); end
    vecs++; if (s_rdata !== 32'd0) begin errs++; $display("FAIL rst_rdata got=%h exp=0", s_rdata); end
    rst = 0; s_araddr = 8'h0C; s_arvalid = 1; s_rready = 1;
    tick;
    vecs++; if (s_rvalid !== 1'b0) begin errs++; $display("FAIL id_rvalid_c1 got=%b exp=0", s_rvalid); end
    tick;
    s_arvalid = 0;
    vecs++; if (s_rvalid !== 1'b1) begin errs++; $display("FAIL id_rvalid_c2 got=%b exp=1", s_rvalid); end
    vecs++; if (s_rdata !== 32'h5B1C_0001) begin errs++; $display("FAIL id_rdata got=%h exp=5b1c0001", s_rdata); end
    vecs++; if (s_rresp !== 2'b00) begin errs++; $display("FAIL id_rresp got=%b exp=00", s_rresp); end
    tick;
    s_rready = 0;
    vecs++; if (s_rvalid !== 1'b0) begin errs++; $display("FAIL id_rvalid_drop got=%b exp=0", s_rvalid); end
    do_read(8'h04, d, r);
    vecs++; if (d !== 32'd49_999_999) begin errs++; $display("FAIL rst_div got=%0d exp=49999999", d); end
    do_read(8'h00, d, r);
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL rst_ctrl got=%h exp=0", d); end
    do_read(8'h08, d, r);
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL rst_scratch got=%h exp=0", d); end
  endtask

  task automatic test_scratch_wfirst;
    logic [31:0] d;
    logic [1:0] r;
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 0;
    tick;
    s_wvalid = 0;
    vecs++; if (s_wready !== 1'b0) begin errs++; $display("FAIL wfirst_wready got=%b exp=0", s_wready); end
    tick; tick;
    vecs++; if (s_bvalid !== 1'b0) begin errs++; $display("FAIL wfirst_early_bvalid got=%b exp=0", s_bvalid); end
    s_awaddr = 8'h08; s_awvalid = 1;
    vecs++; if (s_awready !== 1'b1) begin errs++; $display("FAIL wfirst_awready got=%b exp=1", s_awready); end
    tick;
    s_awvalid = 0;
    vecs++; if (s_bvalid !== 1'b1) begin errs++; $display("FAIL wfirst_bvalid got=%b exp=1", s_bvalid); end
    vecs++; if (s_bresp !== 2'b00) begin errs++; $display("FAIL wfirst_bresp got=%b exp=00", s_bresp); end
    s_bready = 1;
    tick;
    s_bready = 0;
    vecs++; if (s_bvalid !== 1'b0) begin errs++; $display("FAIL wfirst_bdrop got=%b exp=0", s_bvalid); end
    do_write(8'h08, 32'h0000_00AA, 4'b0001, r);
    vecs++; if (r !== 2'b00) begin errs++; $display("FAIL strb_bresp got=%b exp=00", r); end
    do_read(8'h08, d, r);
    vecs++; if (d !== 32'hDEADBEAA) begin errs++; $display("FAIL strb_scratch got=%h exp=deadbeaa", d); end
  endtask

  task automatic test_led_force;
    logic [1:0] r;
    do_write(8'h00, 32'd1, 4'hF, r);
    tick;
    vecs++; if (led !== 1'b1) begin errs++; $display("FAIL led_force_on got=%b exp=1", led); end
    do_write(8'h00, 32'd0, 4'hF, r);
    tick;
    vecs++; if (led !== 1'b0) begin errs++; $display("FAIL led_force_off got=%b exp=0", led); end
  endtask

  task automatic test_blink;
    logic [1:0] r;
    logic prev;
    int last, toggles;
    do_write(8'h04, 32'd3, 4'hF, r);
    do_write(8'h00, 32'd2, 4'hF, r);
    prev = led; last = -1; toggles = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (led !== prev) begin
        if (last >= 0) begin
          vecs++; if (i - last != 4) begin errs++; $display("FAIL blink_period got=%0d exp=4", i - last); end
        end
        last = i; toggles++; prev = led;
      end
    end
    vecs++; if (toggles < 8) begin errs++; $display("FAIL blink_toggles got=%0d exp>=8", toggles); end
    do_write(8'h00, 32'd0, 4'hF, r);
    tick;
    vecs++; if (led !== 1'b0) begin errs++; $display("FAIL blink_off_led got=%b exp=0", led); end
    vecs++; if (dut.blink_cnt !== 32'd0) begin errs++; $display("FAIL blink_off_cnt got=%0d exp=0", dut.blink_cnt); end
    do_write(8'h04, 32'd0, 4'hF, r);
    do_write(8'h00, 32'd2, 4'hF, r);
    tick;
    prev = led;
    for (int i = 0; i < 4; i++) begin
      tick;
      vecs++; if (led !== ~prev) begin errs++; $display("FAIL div0_toggle got=%b exp=%b", led, ~prev); end
      prev = led;
    end
    do_write(8'h00, 32'd0, 4'hF, r);
  endtask

  task automatic test_unmapped;
    logic [31:0] d, d2;
    logic [1:0] r;
    do_write(8'h14, 32'hFFFF_FFFF, 4'hF, r);
    vecs++; if (r !== 2'b10) begin errs++; $display("FAIL unmap_bresp got=%b exp=10", r); end
    do_read(8'h14, d, r);
    vecs++; if (r !== 2'b10) begin errs++; $display("FAIL unmap_rresp got=%b exp=10", r); end
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL unmap_rdata got=%h exp=0", d); end
    do_write(8'h0C, 32'h1234_5678, 4'hF, r);
    vecs++; if (r !== 2'b00) begin errs++; $display("FAIL id_wr_bresp got=%b exp=00", r); end
    do_read(8'h0C, d, r);
    vecs++; if (d !== 32'h5B1C_0001) begin errs++; $display("FAIL id_after_wr got=%h exp=5b1c0001", d); end
    do_read(8'h08, d, r);
    vecs++; if (d !== 32'hDEADBEAA) begin errs++; $display("FAIL unmap_scratch got=%h exp=deadbeaa", d); end
    do_read(8'h00, d, r);
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL unmap_ctrl got=%h exp=0", d); end
    do_read(8'h04, d, r);
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL unmap_div got=%h exp=0", d); end
`ifdef SB_BLINK_CNT_READ_EN
    do_write(8'h04, 32'd1000, 4'hF, r);
    do_write(8'h00, 32'd2, 4'hF, r);
    do_write(8'h10, 32'd0, 4'hF, r);
    vecs++; if (r !== 2'b00) begin errs++; $display("FAIL cnt_wr_bresp got=%b exp=00", r); end
    do_read(8'h10, d, r);
    vecs++; if (r !== 2'b00 || d == 32'd0) begin errs++; $display("FAIL cnt_read1 got=%0d/%b exp=nonzero/00", d, r); end
    do_read(8'h10, d2, r);
    vecs++; if (d2 <= d) begin errs++; $display("FAIL cnt_read2 got=%0d exp>%0d", d2, d); end
    do_write(8'h00, 32'd0, 4'hF, r);
`else
    do_write(8'h10, 32'd5, 4'hF, r);
    vecs++; if (r !== 2'b10) begin errs++; $display("FAIL cnt_wr_bresp got=%b exp=10", r); end
    do_read(8'h10, d2, r);
    vecs++; if (r !== 2'b10 || d2 !== 32'd0) begin errs++; $display("FAIL cnt_read got=%h/%b exp=0/10", d2, r); end
`endif
  endtask

  task automatic test_stall_reset;
    logic [31:0] d;
    logic [1:0] r;
    do_write(8'h00, 32'd1, 4'hF, r);
    s_bready = 0; s_rready = 0;
    s_awaddr = 8'h08; s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 8'h0C; s_arvalid = 1;
    tick;
    s_awaddr = 8'h00; s_wdata = 32'd0; s_araddr = 8'h08;
    for (int i = 0; i < 10; i++) begin
      vecs++; if ({s_bvalid, s_bresp} !== 3'b100) begin errs++; $display("FAIL stall_b c%0d got=%b exp=100", i, {s_bvalid, s_bresp}); end
      vecs++; if ({s_rvalid, s_rresp} !== 3'b100 || s_rdata !== 32'h5B1C_0001) begin errs++; $display("FAIL stall_r c%0d got=%b/%h exp=100/5b1c0001", i, {s_rvalid, s_rresp}, s_rdata); end
      vecs++; if ({s_awready, s_arready} !== 2'b00) begin errs++; $display("FAIL stall_ready c%0d got=%b exp=00", i, {s_awready, s_arready}); end
      tick;
    end
    rst = 1; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    tick;
    vecs++; if ({s_bvalid, s_rvalid, s_awready, s_arready, led} !== 5'd0) begin errs++; $display("FAIL midrst_outputs got=%b exp=00000", {s_bvalid, s_rvalid, s_awready, s_arready, led}); end
    rst = 0;
    tick;
    do_read(8'h00, d, r);
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL midrst_ctrl got=%h exp=0", d); end
    do_read(8'h08, d, r);
    vecs++; if (d !== 32'd0) begin errs++; $display("FAIL midrst_scratch got=%h exp=0", d); end
  endtask

  initial begin
    test_reset;
    test_scratch_wfirst;
    test_led_force;
    test_blink;
    test_unmapped;
    test_stall_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
